alu_req_driver: RTL and testbench

Initiator side of the 4-bit ALU slice interface (a/b/sel in, out/cf/of/zf back).
- Accepts operation requests on a valid/ready channel and drives the combinational ALU slice from registers.
- Holds the ALU inputs stable for a settle window, then captures result and flags.
- Returns the captured result on a valid/ready response channel. Sits between the command source (test sequencer / CPU stub) and the ALU slice.

---
 rtl/alu_req_driver_pkg.sv | 26 ++
 rtl/alu_req_driver_if.sv | 24 ++
 rtl/alu_req_driver.sv | 99 +++++++++
 tb/tb_alu_req_driver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_driver_pkg.sv
// Shared definitions for the ALU request driver: op codes, FSM states, op classification.
package alu_req_driver_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_LT  = 3'b110,
        ALU_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Only the adder paths produce meaningful carry/overflow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// Request/response channels between a command source (master) and the ALU driver (slave).
interface alu_req_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_out;
    logic       rsp_cf;
    logic       rsp_of;
    logic       rsp_zf;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_cf, rsp_of, rsp_zf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_cf, rsp_of, rsp_zf
    );
endinterface

// File: rtl/alu_req_driver.sv
// Drives a combinational 4-bit ALU slice from registers and returns the sampled result.
// Latency: response valid SETTLE cycles after the accept edge.
// Backpressure: one op in flight; ALU_REQ_OVERLAP_EN lets a new request enter on the retire edge.
module alu_req_driver
    import alu_req_driver_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_driver_if.slave   io,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [3:0]        alu_out,
    input  logic              alu_cf,
    input  logic              alu_of,
    input  logic              alu_zf,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0]       LAST    = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q;
    logic       req_rdy;
    logic       accept;
    logic       retire;
    logic       done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DRIVE;
            DRIVE:   if (done)   state_d = RESP;
            RESP:    if (retire) state_d = accept ? DRIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_rdy = 1'b0;
`ifdef ALU_REQ_OVERLAP_EN
        req_rdy = (state_q == IDLE) || ((state_q == RESP) && io.rsp_ready);
`else
        req_rdy = (state_q == IDLE);
`endif
        accept = io.req_valid && req_rdy;
        retire = (state_q == RESP) && io.rsp_ready;
        done   = (state_q == DRIVE) && (cnt_q == LAST);
    end

    assign io.req_ready = req_rdy;
    assign io.rsp_valid = (state_q == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 3'b000;
            cnt_q     <= '0;
            io.rsp_out <= '0;
            io.rsp_cf  <= 1'b0;
            io.rsp_of  <= 1'b0;
            io.rsp_zf  <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                alu_a   <= io.req_a;
                alu_b   <= io.req_b;
                alu_sel <= io.req_op;
                cnt_q   <= '0;
            end else if (state_q == DRIVE) begin
                cnt_q <= cnt_q + 4'd1;
            end
            // Logic ops leave the slice's flag outputs undefined, so they are masked here.
            if (done) begin
                io.rsp_out <= alu_out;
                io.rsp_zf  <= alu_zf;
                io.rsp_cf  <= is_arith(alu_sel) && alu_cf;
                io.rsp_of  <= is_arith(alu_sel) && alu_of;
            end
            if (retire) begin
                op_count <= op_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: scoreboard model on a SETTLE=1 instance plus directed latency/reset on SETTLE=4.
module tb_alu_req_driver;
    import alu_req_driver_pkg::*;

    localparam int unsigned S0 = 1;
    localparam int unsigned S1 = 4;
`ifdef ALU_REQ_OVERLAP_EN
    localparam int SPACING = S0 + 1;
`else
    localparam int SPACING = S0 + 2;
`endif

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_req_driver_if io0();
    alu_req_driver_if io1();

    logic [3:0]  a0, b0, o0, a1, b1, o1;
    logic [2:0]  s0, s1;
    logic        cf0, of0, zf0, cf1, of1, zf1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    alu_req_driver #(.SETTLE(S0), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst0), .io(io0),
        .alu_a(a0), .alu_b(b0), .alu_sel(s0),
        .alu_out(o0), .alu_cf(cf0), .alu_of(of0), .alu_zf(zf0),
        .op_count(cnt0)
    );

    alu_req_driver #(.SETTLE(S1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst1), .io(io1),
        .alu_a(a1), .alu_b(b1), .alu_sel(s1),
        .alu_out(o1), .alu_cf(cf1), .alu_of(of1), .alu_zf(zf1),
        .op_count(cnt1)
    );

    // Returns {out, cf, of, zf}. With spec=0 it models the slice, whose flags are junk for logic ops.
    function automatic logic [6:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op, input logic spec);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, o;
        s = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                          o = (a[3] == b[3]) && (r[3] != a[3]); end
            3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                          o = (a[3] != b[3]) && (r[3] != a[3]); end
            3'b010: r = ~a;
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = {3'b000, a < b};
            default: r = {3'b000, a == b};
        endcase
        if (!spec && op >= 3'b010) begin
            c = a[0];
            o = b[0] | a[1];
        end
        return {r, c, o, r == 4'd0};
    endfunction

    always_comb {o0, cf0, of0, zf0} = alu_calc(a0, b0, s0, 1'b0);
    always_comb {o1, cf1, of1, zf1} = alu_calc(a1, b1, s1, 1'b0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model of u0: one op in flight, result due SETTLE edges after accept.
    bit         m_valid, m_pend, m_ready, m_retire, m_accept;
    int         m_rem;
    logic [6:0] m_rsp;
    logic [3:0] m_a, m_b, m_cnt;
    logic [2:0] m_op;

    always @(negedge clk) begin
        if (rst0) begin
            m_valid = 1'b0; m_pend = 1'b0; m_rem = 0; m_rsp = '0;
            m_a = '0; m_b = '0; m_op = '0; m_cnt = '0;
        end else begin
            m_ready = !m_pend && !m_valid;
`ifdef ALU_REQ_OVERLAP_EN
            if (m_valid && io0.rsp_ready) m_ready = 1'b1;
`endif
            chk("m_req_ready", 32'(io0.req_ready), 32'(m_ready));
            chk("m_rsp_valid", 32'(io0.rsp_valid), 32'(m_valid));
            chk("m_op_count", 32'(cnt0), 32'(m_cnt));
            chk("m_alu_in", 32'({a0, b0, s0}), 32'({m_a, m_b, m_op}));
            if (m_valid)
                chk("m_rsp", 32'({io0.rsp_out, io0.rsp_cf, io0.rsp_of, io0.rsp_zf}), 32'(m_rsp));
            m_retire = m_valid && io0.rsp_ready;
            m_accept = io0.req_valid && m_ready;
            if (m_pend) begin
                m_rem--;
                if (m_rem == 0) begin m_pend = 1'b0; m_valid = 1'b1; end
            end
            if (m_retire) begin m_valid = 1'b0; m_cnt++; end
            if (m_accept) begin
                m_a = io0.req_a; m_b = io0.req_b; m_op = io0.req_op;
                m_rsp = alu_calc(io0.req_a, io0.req_b, io0.req_op, 1'b1);
                m_pend = 1'b1; m_rem = S0;
            end
        end
    end

    task automatic do_req0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit ok;
        ok = 1'b0;
        io0.req_a = a; io0.req_b = b; io0.req_op = op; io0.req_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = io0.req_ready;
        end
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        io0.req_valid = 1'b0;
    endtask

    task automatic get_rsp0(input string nm, input logic [6:0] exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = io0.rsp_valid;
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
        chk(nm, 32'({io0.rsp_out, io0.rsp_cf, io0.rsp_of, io0.rsp_zf}), 32'(exp));
        @(posedge clk); #1;
        io0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        io0.rsp_ready = 1'b0;
    endtask

    // {a, b, op, out, cf, of, zf}
    logic [17:0] tbl [8] = '{
        {4'd2, 4'd5, 3'b001, 4'd13, 1'b1, 1'b0, 1'b0},
        {4'd4, 4'd4, 3'b001, 4'd0,  1'b0, 1'b0, 1'b1},
        {4'd8, 4'd1, 3'b001, 4'd7,  1'b0, 1'b1, 1'b0},
        {4'd5, 4'd3, 3'b010, 4'd10, 1'b0, 1'b0, 1'b0},
        {4'd3, 4'd9, 3'b110, 4'd1,  1'b0, 1'b0, 1'b0},
        {4'd9, 4'd3, 3'b110, 4'd0,  1'b0, 1'b0, 1'b1},
        {4'd6, 4'd6, 3'b111, 4'd1,  1'b0, 1'b0, 1'b0},
        {4'd0, 4'd0, 3'b100, 4'd0,  1'b0, 1'b0, 1'b1}
    };
    logic [3:0] sa [4] = '{4'd2, 4'd3, 4'd9, 4'd0};
    logic [3:0] sb [4] = '{4'd2, 4'd5, 4'd9, 4'd1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit acc;
        int idx, nrsp, last;
        io0.req_valid = 1'b0; io0.req_a = '0; io0.req_b = '0; io0.req_op = '0; io0.rsp_ready = 1'b0;
        io1.req_valid = 1'b0; io1.req_a = '0; io1.req_b = '0; io1.req_op = '0; io1.rsp_ready = 1'b0;
        #22;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(io0.req_ready), 32'd1);
        chk("rst_valid", 32'(io0.rsp_valid), 32'd0);
        chk("rst_rsp", 32'({io0.rsp_out, io0.rsp_cf, io0.rsp_of, io0.rsp_zf}), 32'd0);
        chk("rst_alu", 32'({a0, b0, s0}), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst1_state", 32'({io1.req_ready, io1.rsp_valid, s1}), 32'h10);
        @(posedge clk); #1;

        do_req0(4'd3, 4'd4, 3'b000);
        get_rsp0("add_3_4", {4'd7, 3'b000});
        @(negedge clk);
        chk("count_after_1", 32'(cnt0), 32'd1);
        @(posedge clk); #1;
        do_req0(4'd7, 4'd1, 3'b000);
        get_rsp0("add_7_1", {4'd8, 3'b010});
        do_req0(4'd5, 4'd5, 3'b101);
        get_rsp0("xor_5_5", {4'd0, 3'b001});

        // Hold off the response while a second request waits.
        do_req0(4'd12, 4'd10, 3'b011);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = io0.rsp_valid;
        end
        if (!ok) chk("stall_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        io0.req_a = 4'd1; io0.req_b = 4'd2; io0.req_op = 3'b100; io0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(io0.req_ready), 32'd0);
            chk("stall_rsp", 32'({io0.rsp_valid, io0.rsp_out, io0.rsp_cf, io0.rsp_of, io0.rsp_zf}),
                32'({1'b1, 4'd8, 3'b000}));
            chk("stall_count", 32'(cnt0), 32'd3);
        end
        @(posedge clk); #1;
        io0.req_valid = 1'b0;
        get_rsp0("and_12_10", {4'd8, 3'b000});

        for (int i = 0; i < 8; i++) begin
            do_req0(tbl[i][17:14], tbl[i][13:10], tbl[i][9:7]);
            get_rsp0($sformatf("tbl%0d", i), tbl[i][6:0]);
        end
        @(negedge clk);
        chk("count_12", 32'(cnt0), 32'd12);

        // Streaming EQ ops with both handshakes held high.
        @(posedge clk); #1;
        io0.rsp_ready = 1'b1;
        idx = 0; nrsp = 0; last = 0;
        io0.req_a = sa[0]; io0.req_b = sb[0]; io0.req_op = 3'b111; io0.req_valid = 1'b1;
        for (int i = 0; i < 100 && nrsp < 4; i++) begin
            @(negedge clk);
            if (io0.rsp_valid) begin
                if (nrsp > 0) chk("stream_spacing", 32'(cyc - last), 32'(SPACING));
                last = cyc;
                nrsp++;
            end
            acc = io0.req_ready && io0.req_valid;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin io0.req_a = sa[idx]; io0.req_b = sb[idx]; end
                else io0.req_valid = 1'b0;
            end
        end
        if (nrsp < 4) chk("stream_timeout", 32'(nrsp), 32'd4);
        io0.rsp_ready = 1'b0;
        io0.req_valid = 1'b0;
        @(negedge clk);
        chk("count_wrap", 32'(cnt0), 32'd0);

        // SETTLE=4 instance: exact latency.
        @(posedge clk); #1;
        io1.req_a = 4'd1; io1.req_b = 4'd1; io1.req_op = 3'b000; io1.req_valid = 1'b1;
        @(negedge clk);
        chk("s4_ready", 32'(io1.req_ready), 32'd1);
        @(posedge clk); #1;
        io1.req_valid = 1'b0;
        for (int j = 0; j <= int'(S1); j++) begin
            @(negedge clk);
            chk($sformatf("s4_valid_%0d", j), 32'(io1.rsp_valid), 32'(j == int'(S1)));
        end
        chk("s4_rsp", 32'({io1.rsp_out, io1.rsp_cf, io1.rsp_of, io1.rsp_zf}), 32'({4'd2, 3'b000}));
        @(posedge clk); #1;
        io1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        io1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("s4_count", 32'(cnt1), 32'd1);

        // Reset while driving discards the op.
        @(posedge clk); #1;
        io1.req_a = 4'd2; io1.req_b = 4'd5; io1.req_op = 3'b001; io1.req_valid = 1'b1;
        @(negedge clk);
        chk("s4_ready2", 32'(io1.req_ready), 32'd1);
        @(posedge clk); #1;
        io1.req_valid = 1'b0;
        @(posedge clk); #2;
        rst1 = 1'b1;
        #2;
        rst1 = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(io1.req_ready), 32'd1);
        chk("rstmid_alu", 32'({a1, b1, s1}), 32'd0);
        chk("rstmid_count", 32'(cnt1), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rstmid_valid", 32'(io1.rsp_valid), 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
